// File: rtl/pc_unit_pkg.sv
// Shared defaults and next-PC select encoding for the fetch PC unit.
package pc_unit_pkg;

  localparam int PC_W_DEFAULT = 48;
  localparam logic [PC_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [2:0] {
    SEL_BR,
    SEL_RET,
    SEL_HOLD,
    SEL_RAS,
    SEL_PRED
  } next_sel_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: combinational top read, saturating count,
// oldest entry silently overwritten when a push arrives while full.
module pc_unit_ras_stack
  import pc_unit_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int RAS_DEPTH = 8,
  parameter int RAS_PTR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_addr,
  output logic [PC_W-1:0] top_addr,
  output logic            empty,
  output logic            full
);

  localparam logic [RAS_PTR_W:0] DEPTH_CNT = (RAS_PTR_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0]      mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] top_reg;
  logic [RAS_PTR_W-1:0] top_inc;
  logic [RAS_PTR_W-1:0] top_dec;
  logic [RAS_PTR_W:0]   count_reg;

  assign top_inc  = top_reg + RAS_PTR_W'(1);
  assign top_dec  = top_reg - RAS_PTR_W'(1);
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_CNT);
  assign top_addr = mem[top_reg];

  // Storage has no reset so it can map onto plain distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[top_inc] <= push_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      top_reg <= top_inc;
      if (!full) begin
        count_reg <= count_reg + (RAS_PTR_W + 1)'(1);
      end
    end else if (pop && !empty) begin
      top_reg   <= top_dec;
      count_reg <= count_reg - (RAS_PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC selection, valid flag and a
// return-address stack whose overflow/underflow are latched as sticky errors.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEFAULT),
  parameter int              RAS_DEPTH = 8,
  parameter int              RAS_PTR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic [PC_W-1:0] pred_pc_i,
  input  logic            is_call_i,
  input  logic [PC_W-1:0] call_ret_addr_i,
  input  logic            is_ret_i,
  input  logic            br_mispredict_i,
  input  logic [PC_W-1:0] br_pc_i,
  input  logic            ret_mispredict_i,
  input  logic [PC_W-1:0] ret_pc_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic [1:0]      ras_err_o
);

  next_sel_e       sel;
  logic            push;
  logic            pop;
  logic            underflow;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_reg;
  logic            valid_reg;
  logic [1:0]      err_reg;

  pc_unit_ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PTR_W (RAS_PTR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (call_ret_addr_i),
    .top_addr  (ras_top),
    .empty     (ras_empty_o),
    .full      (ras_full_o)
  );

  // Redirects beat stall; a call beats a simultaneous (illegal) ret.
  always_comb begin
    sel       = SEL_PRED;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    if (!valid_reg) begin
      sel = SEL_HOLD;
    end else if (br_mispredict_i) begin
      sel = SEL_BR;
    end else if (ret_mispredict_i) begin
      sel = SEL_RET;
    end else if (stall_i) begin
      sel = SEL_HOLD;
    end else if (is_call_i) begin
      push = 1'b1;
    end else if (is_ret_i) begin
      if (!ras_empty_o) begin
        sel = SEL_RAS;
        pop = 1'b1;
      end else begin
        underflow = 1'b1;
      end
    end
  end

  always_comb begin
    pc_next = pred_pc_i;
    case (sel)
      SEL_BR:   pc_next = br_pc_i;
      SEL_RET:  pc_next = ret_pc_i;
      SEL_HOLD: pc_next = pc_reg;
      SEL_RAS:  pc_next = ras_top;
      default:  pc_next = pred_pc_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b0;
      err_reg   <= 2'b00;
    end else begin
      pc_reg    <= pc_next;
      valid_reg <= 1'b1;
      err_reg   <= err_reg | {underflow, push & ras_full_o};
    end
  end

  assign pc_o       = pc_reg;
  assign pc_valid_o = valid_reg;
  assign ras_err_o  = err_reg;

endmodule
